// File: rtl/jstk_spi_responder_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : jstk_spi_responder_if                                 |
// | Brief    : SPI mode-0 bus between a host (master) and the        |
// |            PmodJSTK emulating responder (slave).                 |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
interface jstk_spi_responder_if;
  logic ss;    // slave select, active low
  logic sclk;  // host clock, idle low
  logic mosi;  // host -> responder, MSB first
  logic miso;  // responder -> host, MSB first

  modport master (output ss, output sclk, output mosi, input miso);
  modport slave  (input ss, input sclk, input mosi, output miso);
endinterface
`default_nettype wire

// File: rtl/jstk_spi_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : jstk_spi_responder                                    |
// | Brief    : Emulates a Digilent PmodJSTK on SPI mode 0. Each ss   |
// |            window snapshots the joystick inputs into a 5-byte    |
// |            frame shifted out on miso while the host byte stream  |
// |            is captured; the first host byte is reported as       |
// |            cmd_byte once all 40 bits have arrived.               |
// | Options  : define JSTK_LED_CMD_EN to decode LED commands         |
// |            (cmd_byte = 8'b100000_LL) into led_state.             |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module jstk_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  jstk_spi_responder_if.slave   spi,
  input  logic [9:0]            jst_x,
  input  logic [9:0]            jst_y,
  input  logic [2:0]            jst_btn,
  output logic [1:0]            led_state,
  output logic                  frame_done,
  output logic                  frame_abort,
  output logic [7:0]            cmd_byte
);

  // Synchronizer depth clamped to the supported 2..3 range.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : ((SYNC_STAGES > 3) ? 3 : SYNC_STAGES);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [2:0] LAST_BIT  = 3'd7;
  localparam logic [2:0] LAST_BYTE = 3'd4;

  logic [STAGES-1:0] ss_sync;
  logic [STAGES-1:0] sclk_sync;
  logic [STAGES-1:0] mosi_sync;
  logic              ss_prev;
  logic              sclk_prev;

  logic              ss_s;
  logic              sclk_s;
  logic              mosi_s;
  logic              ss_fall;
  logic              ss_rise;
  logic              sclk_rise;
  logic              sclk_fall;

  logic [1:0]        state;
  logic [1:0]        next_state;

  logic [2:0]        bit_cnt;
  logic [2:0]        byte_cnt;
  logic [39:0]       tx_shift;
  logic [7:0]        rx_shift;
  logic [7:0]        first_byte;

  logic              start_frame;
  logic              rx_sample;
  logic              tx_advance;
  logic              frame_end;
  logic              abort_evt;
  logic              miso_out;

  // Synchronizers reset to 0 so that an ss already low at reset release
  // never looks like a fresh falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ss_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_prev   <= 1'b0;
      sclk_prev <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[STAGES-2:0], spi.ss};
      sclk_sync <= {sclk_sync[STAGES-2:0], spi.sclk};
      mosi_sync <= {mosi_sync[STAGES-2:0], spi.mosi};
      ss_prev   <= ss_sync[STAGES-1];
      sclk_prev <= sclk_sync[STAGES-1];
    end
  end

  assign ss_s      = ss_sync[STAGES-1];
  assign sclk_s    = sclk_sync[STAGES-1];
  assign mosi_s    = mosi_sync[STAGES-1];
  assign ss_fall   = ss_prev & ~ss_s;
  assign ss_rise   = ~ss_prev & ss_s;
  assign sclk_rise = ~sclk_prev & sclk_s;
  assign sclk_fall = sclk_prev & ~sclk_s;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; an ss edge always wins over a coincident sclk edge.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (ss_fall) next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (ss_rise)        next_state = ST_IDLE;
        else if (frame_end) next_state = ST_HOLD;
      end
      ST_HOLD: begin
        if (ss_rise) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Output/event decode: datapath strobes and the miso bit.
  always_comb begin
    start_frame = 1'b0;
    rx_sample   = 1'b0;
    tx_advance  = 1'b0;
    frame_end   = 1'b0;
    abort_evt   = 1'b0;
    miso_out    = 1'b0;
    case (state)
      ST_IDLE: begin
        start_frame = ss_fall;
      end
      ST_SHIFT: begin
        miso_out   = tx_shift[39];
        abort_evt  = ss_rise;
        rx_sample  = sclk_rise & ~ss_rise;
        tx_advance = sclk_fall & ~ss_rise;
        frame_end  = rx_sample & (bit_cnt == LAST_BIT) & (byte_cnt == LAST_BYTE);
      end
      default: begin
        miso_out = 1'b0;
      end
    endcase
  end

  assign spi.miso = miso_out;

  // Transmit frame: snapshot at frame start, shift MSB-first on sclk falls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_shift <= '0;
    end else if (start_frame) begin
      tx_shift <= {jst_x[7:0], 6'b0, jst_x[9:8],
                   jst_y[7:0], 6'b0, jst_y[9:8],
                   5'b0, jst_btn};
    end else if (tx_advance) begin
      tx_shift <= {tx_shift[38:0], 1'b0};
    end
  end

  // Receive path: bit/byte counters and capture of the first host byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      rx_shift   <= '0;
      first_byte <= '0;
    end else if (start_frame) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
      rx_shift <= '0;
    end else if (rx_sample) begin
      rx_shift <= {rx_shift[6:0], mosi_s};
      bit_cnt  <= bit_cnt + 3'd1;
      if (bit_cnt == LAST_BIT) begin
        byte_cnt <= byte_cnt + 3'd1;
        if (byte_cnt == 3'd0) begin
          first_byte <= {rx_shift[6:0], mosi_s};
        end
      end
    end
  end

  // Frame results: cmd_byte only updates on a complete frame; pulses are single-cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_byte    <= 8'h00;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_done  <= frame_end;
      frame_abort <= abort_evt;
      if (frame_end) begin
        cmd_byte <= first_byte;
      end
    end
  end

`ifdef JSTK_LED_CMD_EN
  // LED command decode: 8'b100000_LL sets the LED bits, anything else holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_state <= 2'b00;
    end else if (frame_end && (first_byte[7:2] == 6'b100000)) begin
      led_state <= first_byte[1:0];
    end
  end
`else
  assign led_state = 2'b00;
`endif

endmodule
`default_nettype wire
